pwm_meter: RTL and testbench

//  Measures an incoming pulse train, such as a divided/variable-duty clock or LED drive from a

---
 rtl/pwm_meter_pkg.sv | 21 ++
 rtl/pwm_meter_if.sv | 39 +++
 rtl/pwm_meter_sig_sync_edge.sv | 95 +++++++++
 rtl/pwm_meter.sv | 144 ++++++++++++++
 tb/tb_pwm_meter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_meter_pkg.sv
// ============================================================================
// Module      : pwm_meter_pkg
// Description : Shared FSM state encoding and default sizing for pwm_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_meter_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned FILT_LEN_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEAS_HIGH = 2'd1,
    ST_MEAS_LOW  = 2'd2
  } meter_state_e;

endpackage : pwm_meter_pkg

`default_nettype wire

// File: rtl/pwm_meter_if.sv
// ============================================================================
// Module      : pwm_meter_if
// Description : Control/measurement bundle of pwm_meter (enable, pin, results).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_meter_if #(
  parameter int unsigned CNT_W = 16
);

  logic             EN;
  logic             SIG_IN;
  logic [CNT_W-1:0] HIGH_CNT;
  logic [CNT_W-1:0] PERIOD_CNT;
  logic             VALID;
  logic             TIMEOUT;

  modport master (
    output EN,
    output SIG_IN,
    input  HIGH_CNT,
    input  PERIOD_CNT,
    input  VALID,
    input  TIMEOUT
  );

  modport slave (
    input  EN,
    input  SIG_IN,
    output HIGH_CNT,
    output PERIOD_CNT,
    output VALID,
    output TIMEOUT
  );

endinterface : pwm_meter_if

`default_nettype wire

// File: rtl/pwm_meter_sig_sync_edge.sv
// ============================================================================
// Module      : sig_sync_edge
// Description : 2-FF synchronizer, optional deglitch filter (SIG_FILTER_EN),
//               registered rise/fall detector for an asynchronous pin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_sync_edge
`ifdef SIG_FILTER_EN
#(
  parameter int unsigned FILT_LEN = 4
)
`endif
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic sig_in,
  output logic      level,
  output logic      rise,
  output logic      fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic lvl_q,   lvl_d;
  logic rise_q,  rise_d;
  logic fall_q,  fall_d;
  logic stage_lvl;

`ifdef SIG_FILTER_EN
  localparam int unsigned RUN_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic             filt_q, filt_d;
  logic [RUN_W-1:0] run_q,  run_d;

  // run_q counts consecutive synced samples disagreeing with the filtered level
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == RUN_W'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign stage_lvl = filt_q;
`else
  assign stage_lvl = sync2_q;
`endif

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    lvl_d   = stage_lvl;
    rise_d  = stage_lvl & ~lvl_q;
    fall_d  = ~stage_lvl & lvl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule : sig_sync_edge

`default_nettype wire

// File: rtl/pwm_meter.sv
// ============================================================================
// Module      : pwm_meter
// Description : Measures high time and period of SIG_IN in CLK50 cycles.
//               Optional input deglitch filter enabled by `define SIG_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef SIG_FILTER_EN
  ,
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
`endif
)
(
  input  wire logic   CLK50,
  input  wire logic   RST_N,
  pwm_meter_if.slave  bus
);

  logic             sig_level;
  logic             sig_rise;
  logic             sig_fall;

  meter_state_e     state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] high_cap_q,   high_cap_d;
  logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             valid_q,      valid_d;
  logic             timeout_q,    timeout_d;
  logic             cnt_sat;

  sig_sync_edge
`ifdef SIG_FILTER_EN
  #(
    .FILT_LEN (FILT_LEN)
  )
`endif
  u_sync_edge (
    .clk    (CLK50),
    .rst_n  (RST_N),
    .sig_in (bus.SIG_IN),
    .level  (sig_level),
    .rise   (sig_rise),
    .fall   (sig_fall)
  );

  assign cnt_sat = (cnt_q == {CNT_W{1'b1}});

  // A rise always takes priority over saturation so a valid period is never lost
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_cap_d   = high_cap_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    if (!bus.EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sig_rise) begin
            state_d = ST_MEAS_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end

        ST_MEAS_HIGH: begin
          if (sig_rise) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_sat) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (sig_fall) begin
              high_cap_d = cnt_q;
              state_d    = ST_MEAS_LOW;
            end
          end
        end

        ST_MEAS_LOW: begin
          if (sig_rise) begin
            high_cnt_d   = high_cap_q;
            period_cnt_d = cnt_q;
            valid_d      = 1'b1;
            timeout_d    = 1'b0;
            cnt_d        = CNT_W'(1);
            state_d      = ST_MEAS_HIGH;
          end else if (cnt_sat) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      high_cap_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_cap_q   <= high_cap_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.HIGH_CNT   = high_cnt_q;
  assign bus.PERIOD_CNT = period_cnt_q;
  assign bus.VALID      = valid_q;
  assign bus.TIMEOUT    = timeout_q;

  // The filtered level is not needed by the measurement path itself
  logic unused_level;
  assign unused_level = sig_level;

endmodule : pwm_meter

`default_nettype wire

// File: tb/tb_pwm_meter.sv
// ============================================================================
// Module      : tb_pwm_meter
// Description : Directed self-checking bench for pwm_meter (CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_meter;

  localparam int unsigned CW = 8;

  logic CLK50 = 1'b0;
  logic RST_N = 1'b0;

  pwm_meter_if #(.CNT_W(CW)) bus ();

  pwm_meter #(.CNT_W(CW)) dut (
    .CLK50 (CLK50),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK50 = ~CLK50;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int vh[$];
  int vp[$];
  int vt[$];

  always @(posedge CLK50) cyc <= cyc + 1;

  always @(negedge CLK50) begin
    if (bus.VALID === 1'b1) begin
      vh.push_back(int'(bus.HIGH_CNT));
      vp.push_back(int'(bus.PERIOD_CNT));
      vt.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    bus.SIG_IN = v;
    repeat (n) @(negedge CLK50);
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic clrq();
    vh.delete();
    vp.delete();
    vt.delete();
  endtask

  task automatic reenable();
    bus.EN = 1'b0;
    repeat (3) @(negedge CLK50);
    bus.EN = 1'b1;
    repeat (2) @(negedge CLK50);
  endtask

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int spacing(input int q[$]);
    return (q.size() > 1) ? (q[q.size()-1] - q[q.size()-2]) : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.EN     = 1'b0;
    bus.SIG_IN = 1'b0;
    RST_N      = 1'b0;
    repeat (3) @(negedge CLK50);
    chk("rst_high",    32'(bus.HIGH_CNT),   0);
    chk("rst_period",  32'(bus.PERIOD_CNT), 0);
    chk("rst_valid",   32'(bus.VALID),      0);
    chk("rst_timeout", 32'(bus.TIMEOUT),    0);
    RST_N = 1'b1;
    @(negedge CLK50);
    bus.EN = 1'b1;
    drive(1'b0, 4);

    // 1 high / 3 low
    clrq();
    repeat (6) pulse(1, 3);
    drive(1'b0, 6);
    chk("t1_count",   32'(vh.size()),    5);
    chk("t1_high0",   32'(first_of(vh)), 1);
    chk("t1_period0", 32'(first_of(vp)), 4);
    chk("t1_high",    32'(last_of(vh)),  1);
    chk("t1_period",  32'(last_of(vp)),  4);
    chk("t1_spacing", 32'(spacing(vt)),  4);

    // 3 high / 5 low
    reenable();
    clrq();
    repeat (4) pulse(3, 5);
    drive(1'b0, 6);
    chk("t2_count",   32'(vh.size()),   3);
    chk("t2_high",    32'(last_of(vh)), 3);
    chk("t2_period",  32'(last_of(vp)), 8);
    chk("t2_spacing", 32'(spacing(vt)), 8);

    // stuck low after one rise saturates the 8-bit counter
    reenable();
    clrq();
    pulse(2, 300);
    chk("t3_no_valid", 32'(vh.size()),    0);
    chk("t3_timeout",  32'(bus.TIMEOUT),  1);
    chk("t3_hold_per", 32'(bus.PERIOD_CNT), 8);
    pulse(2, 3);
    chk("t3_arm_keeps_to", 32'(bus.TIMEOUT), 1);
    pulse(2, 3);
    pulse(2, 3);
    drive(1'b0, 4);
    chk("t3_count",    32'(vh.size()),   2);
    chk("t3_to_clear", 32'(bus.TIMEOUT), 0);
    chk("t3_high",     32'(last_of(vh)), 2);
    chk("t3_period",   32'(last_of(vp)), 5);

    // EN dropped in MEAS_LOW, with a pulse arriving while disabled
    clrq();
    bus.EN = 1'b0;
    drive(1'b0, 2);
    pulse(3, 5);
    bus.EN = 1'b1;
    drive(1'b0, 3);
    pulse(4, 4);
    chk("t4_no_valid", 32'(vh.size()),      0);
    chk("t4_hold_hi",  32'(bus.HIGH_CNT),   2);
    chk("t4_hold_per", 32'(bus.PERIOD_CNT), 5);
    pulse(4, 4);
    drive(1'b0, 4);
    chk("t4_count",  32'(vh.size()),   1);
    chk("t4_high",   32'(last_of(vh)), 4);
    chk("t4_period", 32'(last_of(vp)), 8);

    // asynchronous reset mid-period
    drive(1'b1, 2);
    RST_N = 1'b0;
    #1;
    chk("t5_rst_high",    32'(bus.HIGH_CNT),   0);
    chk("t5_rst_period",  32'(bus.PERIOD_CNT), 0);
    chk("t5_rst_valid",   32'(bus.VALID),      0);
    chk("t5_rst_timeout", 32'(bus.TIMEOUT),    0);
    bus.SIG_IN = 1'b0;
    repeat (3) @(negedge CLK50);
    RST_N = 1'b1;
    drive(1'b0, 3);
    clrq();
    repeat (3) pulse(3, 4);
    drive(1'b0, 4);
    chk("t5_count",  32'(vh.size()),   2);
    chk("t5_high",   32'(last_of(vh)), 3);
    chk("t5_period", 32'(last_of(vp)), 7);

    // 10/10 waveform with a 2-cycle high glitch in the low phase
    reenable();
    clrq();
    drive(1'b1, 10);
    drive(1'b0, 4);
    drive(1'b1, 2);
    drive(1'b0, 4);
    repeat (2) pulse(10, 10);
    drive(1'b1, 10);
    drive(1'b0, 6);
`ifdef SIG_FILTER_EN
    chk("t6_count",   32'(vh.size()),    3);
    chk("t6_period0", 32'(first_of(vp)), 20);
`else
    chk("t6_count",   32'(vh.size()),    4);
    chk("t6_period0", 32'(first_of(vp)), 14);
`endif
    chk("t6_high0",  32'(first_of(vh)), 10);
    chk("t6_high",   32'(last_of(vh)),  10);
    chk("t6_period", 32'(last_of(vp)),  20);

    // stuck high saturates in MEAS_HIGH
    drive(1'b1, 300);
    chk("t7_timeout", 32'(bus.TIMEOUT),  1);
    chk("t7_hold_hi", 32'(bus.HIGH_CNT), 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pwm_meter

`default_nettype wire
